smmha_engine: RTL
=================

SMMHA_ENGINE -- requirements
Module: smmha_engine

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the stream data width in bits.
REQ-002 The module SHALL have parameter CNT_LEN, default smmha_package::MAC_CNT_LEN (1024), giving the maximum elements per job.
REQ-003 The module SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 The module SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The module SHALL have port ctrl_i, input, ctrl_engine_t: clear, start, len, operand, operaton (opcode).
REQ-006 The module SHALL have port flags_o, output, flags_engine_t: cnt, plus the new fields busy and done.
REQ-007 The module SHALL have port a_valid_i, input, 1 bit: input element valid.
REQ-008 The module SHALL have port a_ready_o, output, 1 bit: engine accepts input.
REQ-009 The module SHALL have port a_data_i, input, DATA_WIDTH bits: input element.
REQ-010 The module SHALL have port d_valid_o, output, 1 bit: result valid.
REQ-011 The module SHALL have port d_ready_i, input, 1 bit: downstream accepts result.
REQ-012 The module SHALL have port d_data_o, output, DATA_WIDTH bits: result element.

Function
REQ-013 The engine SHALL implement the consuming end of ctrl_engine_t and the producing end of flags_engine_t, with FSM states IDLE, RUN, DONE.
REQ-014 In IDLE, start=1 SHALL latch len, operand and operaton into internal registers and move to RUN next cycle; start outside IDLE SHALL be ignored.
REQ-015 A latched len of 0 SHALL move directly from IDLE to DONE, with no stream traffic.
REQ-016 A latched len greater than CNT_LEN SHALL saturate to CNT_LEN.
REQ-017 Stream transfers SHALL follow valid/ready: a transfer happens when valid and ready are both 1 on a rising edge; valid SHALL NOT depend combinationally on ready; data SHALL be held stable while valid=1 and ready=0.
REQ-018 The datapath SHALL be one registered stage: a_ready_o = (state==RUN) && (in_cnt < len) && (!d_valid_o || d_ready_i); an accepted input appears on d_data_o the following cycle (latency 1), with full throughput of 1 element/cycle.
REQ-019 The opcode SHALL select the operation, all results truncated to DATA_WIDTH: 0 add operand; 1 subtract operand; 2 multiply by operand (low half); 3 AND; 4 OR; 5 XOR; 6 logical shift left by operand[4:0]; any other value passes a_data_i through.
REQ-020 flags_o.cnt SHALL count completed d-side handshakes in the current job; width $clog2(CNT_LEN)+1; it is not cleared by start.
REQ-021 On the d handshake that makes cnt equal len, the FSM SHALL go RUN->DONE.
REQ-022 DONE SHALL last exactly one cycle with flags_o.done=1, then return to IDLE; flags_o.busy SHALL be 1 in RUN and DONE.
REQ-023 clear=1 SHALL, synchronously and in any state, drop d_valid_o, zero cnt and the internal in_cnt, and go to IDLE; clear SHALL take priority over start and over any handshake in the same cycle.
REQ-024 Inputs offered beyond len SHALL not be accepted (a_ready_o=0).

Reset
REQ-025 While rst_i=1 the engine SHALL asynchronously enter IDLE.
REQ-026 While rst_i=1 the outputs SHALL be d_valid_o=0, d_data_o=0, a_ready_o=0, cnt=0, busy=0, done=0, and the latched registers SHALL be 0.
REQ-027 Reset asserted mid-job SHALL abandon the job with no further output.

Structure
REQ-028 flags_engine_t in smmha_package SHALL gain fields busy and done.
REQ-029 smmha_package SHALL gain opcode constants SMMHA_OP_ADD..SMMHA_OP_SHL and an engine-state enum (ENG_IDLE, ENG_RUN, ENG_DONE).
REQ-030 The ALU SHALL be a purely combinational sub-module, smmha_engine_alu.

Verification
REQ-031 Scenario, basic add: op=0, operand=5, len=4, inputs 1,2,3,4, d_ready=1 -> outputs 6,7,8,9 on consecutive cycles; done pulses once; final cnt=4.
REQ-032 Scenario, backpressure: op=2, operand=3, len=3, d_ready toggling 1,0,1,0 -> outputs 3x inputs in order, d_data_o stable while stalled, no loss or duplication.
REQ-033 Scenario, zero length: len=0, start -> DONE on the next cycle, done=1 for one cycle, and no a_ready_o ever asserted.
REQ-034 Scenario, clear mid-job: len=8, clear after 3 outputs -> d_valid_o=0 next cycle, cnt=0, IDLE; a following start with len=2 completes normally.
REQ-035 Scenario, async reset: rst_i asserted mid-job between clock edges -> outputs go to reset values immediately, without waiting for a clock edge.
REQ-036 Scenario, opcode and saturation: opcode 9 with len=2000 -> pass-through data and exactly 1024 outputs.

Source files
------------

// File: rtl/smmha_engine_pkg.sv
// smmha_package: shared types and constants for the smmha stream engine.
//   ctrl_engine_t  : control bundle consumed by the engine (clear/start/len/operand/opcode)
//   flags_engine_t : status bundle produced by the engine (cnt/busy/done)
//   SMMHA_OP_*     : opcode encodings; any other value passes data through
//   eng_state_e    : engine FSM states
package smmha_package;

  localparam int unsigned MAC_CNT_LEN = 1024;
  localparam int unsigned MAC_CNT_W   = $clog2(MAC_CNT_LEN) + 1;
  localparam int unsigned MAC_DATA_W  = 32;
  localparam int unsigned ENG_LEN_W   = 16;
  localparam int unsigned ENG_OP_W    = 4;

  localparam logic [ENG_OP_W-1:0] SMMHA_OP_ADD = 4'd0;
  localparam logic [ENG_OP_W-1:0] SMMHA_OP_SUB = 4'd1;
  localparam logic [ENG_OP_W-1:0] SMMHA_OP_MUL = 4'd2;
  localparam logic [ENG_OP_W-1:0] SMMHA_OP_AND = 4'd3;
  localparam logic [ENG_OP_W-1:0] SMMHA_OP_OR  = 4'd4;
  localparam logic [ENG_OP_W-1:0] SMMHA_OP_XOR = 4'd5;
  localparam logic [ENG_OP_W-1:0] SMMHA_OP_SHL = 4'd6;

  typedef enum logic [1:0] {
    ENG_IDLE = 2'd0,
    ENG_RUN  = 2'd1,
    ENG_DONE = 2'd2
  } eng_state_e;

  typedef struct packed {
    logic                  clear;
    logic                  start;
    logic [ENG_LEN_W-1:0]  len;
    logic [MAC_DATA_W-1:0] operand;
    logic [ENG_OP_W-1:0]   operaton;
  } ctrl_engine_t;

  typedef struct packed {
    logic [MAC_CNT_W-1:0] cnt;
    logic                 busy;
    logic                 done;
  } flags_engine_t;

endpackage

// File: rtl/smmha_engine_alu.sv
// smmha_engine_alu: purely combinational element operation for the engine.
//   op_i      : opcode (SMMHA_OP_*), unknown codes pass a_i through
//   operand_i : second operand latched at job start
//   a_i       : stream element
//   res_o     : result, truncated to DATA_WIDTH
module smmha_engine_alu
  import smmha_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [ENG_OP_W-1:0]   op_i,
  input  logic [DATA_WIDTH-1:0] operand_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  output logic [DATA_WIDTH-1:0] res_o
);

  always_comb begin
    res_o = a_i;
    unique case (op_i)
      SMMHA_OP_ADD: res_o = a_i + operand_i;
      SMMHA_OP_SUB: res_o = a_i - operand_i;
      SMMHA_OP_MUL: res_o = a_i * operand_i;  // low half only
      SMMHA_OP_AND: res_o = a_i & operand_i;
      SMMHA_OP_OR:  res_o = a_i | operand_i;
      SMMHA_OP_XOR: res_o = a_i ^ operand_i;
      SMMHA_OP_SHL: res_o = a_i << operand_i[4:0];
      default:      res_o = a_i;
    endcase
  end

endmodule

// File: rtl/smmha_engine.sv
// smmha_engine: job-based stream engine. A start in IDLE latches len/operand/opcode,
// then len elements flow a -> ALU -> one output register -> d with valid/ready.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   ctrl_i              : clear/start/len/operand/opcode
//   flags_o             : cnt (completed d handshakes), busy (RUN/DONE), done (1-cycle pulse)
//   a_valid_i/a_ready_o/a_data_i : input stream
//   d_valid_o/d_ready_i/d_data_o : result stream
module smmha_engine
  import smmha_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_LEN    = MAC_CNT_LEN
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  ctrl_engine_t          ctrl_i,
  output flags_engine_t         flags_o,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  output logic                  d_valid_o,
  input  logic                  d_ready_i,
  output logic [DATA_WIDTH-1:0] d_data_o
);

  localparam int unsigned CntW = $clog2(CNT_LEN) + 1;

  eng_state_e            state_q, state_d;
  logic [CntW-1:0]       len_q, len_d;
  logic [DATA_WIDTH-1:0] operand_q, operand_d;
  logic [ENG_OP_W-1:0]   op_q, op_d;
  logic [CntW-1:0]       in_cnt_q, in_cnt_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  d_valid_q, d_valid_d;
  logic [DATA_WIDTH-1:0] d_data_q, d_data_d;

  logic [DATA_WIDTH-1:0] alu_res;
  logic [CntW-1:0]       len_sat;
  logic [CntW-1:0]       cnt_inc;
  logic                  a_ready, a_fire, d_fire;

  smmha_engine_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op_i     (op_q),
    .operand_i(operand_q),
    .a_i      (a_data_i),
    .res_o    (alu_res)
  );

  // The output register may refill in the same cycle it drains.
  assign a_ready = (state_q == ENG_RUN) && (in_cnt_q < len_q) && (!d_valid_q || d_ready_i);
  assign a_fire  = a_valid_i && a_ready;
  assign d_fire  = d_valid_q && d_ready_i;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    if (32'(ctrl_i.len) > CNT_LEN) begin
      len_sat = CntW'(CNT_LEN);
    end else begin
      len_sat = CntW'(ctrl_i.len);
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    operand_d = operand_q;
    op_d      = op_q;
    in_cnt_d  = in_cnt_q;
    cnt_d     = cnt_q;
    d_valid_d = d_valid_q;
    d_data_d  = d_data_q;

    if (ctrl_i.clear) begin
      state_d   = ENG_IDLE;
      in_cnt_d  = '0;
      cnt_d     = '0;
      d_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ENG_IDLE: begin
          if (ctrl_i.start) begin
            len_d     = len_sat;
            operand_d = ctrl_i.operand[DATA_WIDTH-1:0];
            op_d      = ctrl_i.operaton;
            state_d   = (len_sat == '0) ? ENG_DONE : ENG_RUN;
          end
        end
        ENG_RUN: begin
          if (d_fire) begin
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) begin
              state_d = ENG_DONE;
            end
          end
          if (a_fire) begin
            in_cnt_d  = in_cnt_q + 1'b1;
            d_valid_d = 1'b1;
            d_data_d  = alu_res;
          end else if (d_fire) begin
            d_valid_d = 1'b0;
          end
        end
        ENG_DONE: begin
          // cnt stays visible through the done pulse, then rearms for the next job.
          state_d  = ENG_IDLE;
          cnt_d    = '0;
          in_cnt_d = '0;
        end
        default: state_d = ENG_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ENG_IDLE;
      len_q     <= '0;
      operand_q <= '0;
      op_q      <= '0;
      in_cnt_q  <= '0;
      cnt_q     <= '0;
      d_valid_q <= 1'b0;
      d_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      operand_q <= operand_d;
      op_q      <= op_d;
      in_cnt_q  <= in_cnt_d;
      cnt_q     <= cnt_d;
      d_valid_q <= d_valid_d;
      d_data_q  <= d_data_d;
    end
  end

  assign a_ready_o = a_ready;
  assign d_valid_o = d_valid_q;
  assign d_data_o  = d_data_q;

  always_comb begin
    flags_o      = '0;
    flags_o.cnt  = MAC_CNT_W'(cnt_q);
    flags_o.busy = (state_q == ENG_RUN) || (state_q == ENG_DONE);
    flags_o.done = (state_q == ENG_DONE);
  end

endmodule
